// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - shares one framebuffer RAM between VGA scan-out and a queued host write port
module vga_fb_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 19,
  parameter int FB_SIZE    = 307200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            i_VGA_CLOCK,
  input  logic                            i_rst_n,
  input  logic                            i_de,
  input  logic                            i_vsync,
  input  logic                            i_wr_valid,
  output logic                            o_wr_ready,
  input  logic [ADDR_W-1:0]               i_wr_addr,
  input  logic [DATA_W-1:0]               i_wr_data,
  output logic [ADDR_W-1:0]               o_mem_addr,
  output logic                            o_mem_we,
  output logic [DATA_W-1:0]               o_mem_wdata,
  input  logic [DATA_W-1:0]               i_mem_rdata,
  output logic [DATA_W-1:0]               o_pix,
  output logic                            o_pix_valid,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'b00, READ = 2'b01, WRITE = 2'b10} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   scan_addr;
  logic                de_d1;
  logic                de_d2;
  logic                full;
  logic                push;
  logic                pop;

  // Ready comes from the registered count, so a pop while full frees a slot only next cycle.
  assign full       = (cnt == CNT_W'(FIFO_DEPTH));
  assign o_wr_ready = i_rst_n & ~full;
  assign push       = i_wr_valid & o_wr_ready;
  assign pop        = ~i_de & (cnt != '0);
  assign o_fifo_cnt = cnt;
  assign o_mem_we   = (state == WRITE);

  always_ff @(posedge i_VGA_CLOCK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= i_wr_addr;
      fifo_data[wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_VGA_CLOCK) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      scan_addr   <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      de_d1       <= 1'b0;
      de_d2       <= 1'b0;
      o_pix       <= '0;
      o_pix_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;

      // Scan-out wins outright while de is high; writes only drain in blanking.
      if (i_de) begin
        state      <= READ;
        o_mem_addr <= scan_addr;
      end else if (pop) begin
        state       <= WRITE;
        o_mem_addr  <= fifo_addr[rd_ptr];
        o_mem_wdata <= fifo_data[rd_ptr];
      end else begin
        state <= IDLE;
      end

      if (!i_vsync)
        scan_addr <= '0;
      else if (i_de)
        scan_addr <= (scan_addr == ADDR_W'(FB_SIZE - 1)) ? '0 : scan_addr + 1'b1;

      // de -> address (t+1) -> RAM data (t+2) -> pixel register (t+3)
      de_d1       <= i_de;
      de_d2       <= de_d1;
      o_pix_valid <= de_d2;
      o_pix       <= de_d2 ? i_mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;
  localparam int TB_FB = 1280;

  logic        clk = 1'b0;
  logic        rst_n, de, vsync, wr_valid, wr_ready, mem_we, pix_valid;
  logic [18:0] wr_addr, mem_addr;
  logic [7:0]  wr_data, mem_wdata, mem_rdata, pix;
  logic [4:0]  fifo_cnt;
  int          errors = 0;
  int          checks = 0;

  vga_fb_arbiter #(.DATA_W(8), .ADDR_W(19), .FB_SIZE(TB_FB), .FIFO_DEPTH(16)) dut (
    .i_VGA_CLOCK(clk), .i_rst_n(rst_n), .i_de(de), .i_vsync(vsync),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_pix(pix), .o_pix_valid(pix_valid), .o_fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] f(input logic [18:0] a);
    logic [18:0] t;
    t = a * 19'd7 + 19'd3;
    return t[7:0];
  endfunction

  logic [7:0]  mem [0:4095];
  bit   [4095:0] wflag;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[11:0]]   <= mem_wdata;
      wflag[mem_addr[11:0]] <= 1'b1;
    end
    mem_rdata <= wflag[mem_addr[11:0]] ? mem[mem_addr[11:0]] : f(mem_addr);
  end

  function automatic logic [7:0] rd(input logic [18:0] a);
    return wflag[a[11:0]] ? mem[a[11:0]] : f(a);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", wr_ready); end
    checks++; if ({mem_addr, mem_we, mem_wdata, pix, pix_valid, fifo_cnt} !== '0) begin
      errors++; $display("FAIL reset_outputs addr=%h we=%b wd=%h pix=%h pv=%b cnt=%0d exp=all0",
                         mem_addr, mem_we, mem_wdata, pix, pix_valid, fifo_cnt); end
    rst_n = 1'b1;
    step();
    checks++; if ({mem_addr, mem_we, mem_wdata, pix, pix_valid, fifo_cnt} !== '0) begin
      errors++; $display("FAIL release_outputs addr=%h we=%b pix=%h pv=%b cnt=%0d exp=all0",
                         mem_addr, mem_we, pix, pix_valid, fifo_cnt); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", wr_ready); end
  endtask

  task automatic test_scan_line();
    int nvalid = 0;
    logic       ev;
    logic [7:0] ep;
    for (int k = 0; k < 644; k++) begin
      de = (k < 640);
      step();
      checks++; if (mem_addr !== 19'((k < 640) ? k : 639)) begin
        errors++; $display("FAIL scan_addr k=%0d got=%0d exp=%0d", k, mem_addr, (k < 640) ? k : 639); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL scan_we k=%0d got=%b exp=0", k, mem_we); end
      ev = (k >= 2) && (k - 2 < 640);
      ep = ev ? f(19'(k - 2)) : 8'h00;
      if (pix_valid === 1'b1) nvalid++;
      checks++; if (pix_valid !== ev || pix !== ep) begin
        errors++; $display("FAIL scan_pix k=%0d got=%b/%h exp=%b/%h", k, pix_valid, pix, ev, ep); end
    end
    checks++; if (nvalid != 640) begin errors++; $display("FAIL scan_valid_count got=%0d exp=640", nvalid); end
  endtask

  task automatic test_drain_in_blanking();
    logic [18:0] ea [3] = '{19'h300, 19'h301, 19'h302};
    logic [7:0]  ed [3] = '{8'h11, 8'h22, 8'h33};
    de = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = ea[i]; wr_data = ed[i];
      step();
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL drain_we_during_de i=%0d got=%b exp=0", i, mem_we); end
    end
    wr_valid = 1'b0;
    step();
    checks++; if (mem_we !== 1'b0 || fifo_cnt !== 5'd3) begin
      errors++; $display("FAIL drain_hold we=%b cnt=%0d exp=0/3", mem_we, fifo_cnt); end
    de = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (mem_we !== 1'b1 || mem_addr !== ea[i] || mem_wdata !== ed[i]) begin
        errors++; $display("FAIL drain_write i=%0d got=%b/%h/%h exp=1/%h/%h", i, mem_we, mem_addr, mem_wdata, ea[i], ed[i]); end
    end
    step();
    checks++; if (mem_we !== 1'b0 || fifo_cnt !== 5'd0) begin
      errors++; $display("FAIL drain_done we=%b cnt=%0d exp=0/0", mem_we, fifo_cnt); end
    checks++; if (rd(19'h301) !== 8'h22) begin errors++; $display("FAIL drain_ram got=%h exp=22", rd(19'h301)); end
  endtask

  task automatic test_fifo_full();
    de = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready_before i=%0d got=%b exp=1", i, wr_ready); end
      wr_valid = 1'b1; wr_addr = 19'h100 + 19'(i); wr_data = 8'h80 + 8'(i);
      step();
    end
    checks++; if (fifo_cnt !== 5'd16 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL full_state cnt=%0d ready=%b exp=16/0", fifo_cnt, wr_ready); end
    wr_addr = 19'h1FF; wr_data = 8'hEE;
    step(); step();
    checks++; if (fifo_cnt !== 5'd16 || wr_ready !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL full_held cnt=%0d ready=%b we=%b exp=16/0/0", fifo_cnt, wr_ready, mem_we); end
    de = 1'b0;
    step();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 19'h100 || mem_wdata !== 8'h80 || fifo_cnt !== 5'd15 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL full_first_pop we=%b addr=%h wd=%h cnt=%0d ready=%b exp=1/100/80/15/1",
                         mem_we, mem_addr, mem_wdata, fifo_cnt, wr_ready); end
    step();
    wr_valid = 1'b0;
    checks++; if (fifo_cnt !== 5'd15) begin errors++; $display("FAIL full_push_pop_cnt got=%0d exp=15", fifo_cnt); end
    for (int i = 1; i < 17; i++) begin
      logic [18:0] xa;
      logic [7:0]  xd;
      xa = (i < 16) ? 19'h100 + 19'(i) : 19'h1FF;
      xd = (i < 16) ? 8'h80 + 8'(i) : 8'hEE;
      if (i > 1) step();
      checks++; if (mem_we !== 1'b1 || mem_addr !== xa || mem_wdata !== xd) begin
        errors++; $display("FAIL full_order i=%0d got=%b/%h/%h exp=1/%h/%h", i, mem_we, mem_addr, mem_wdata, xa, xd); end
    end
    step();
    checks++; if (mem_we !== 1'b0 || fifo_cnt !== 5'd0) begin
      errors++; $display("FAIL full_drained we=%b cnt=%0d exp=0/0", mem_we, fifo_cnt); end
  endtask

  task automatic test_frame_wrap();
    int exp_a = 0;
    int reads = 0;
    de = 1'b0; vsync = 1'b0;
    step();
    vsync = 1'b1;
    for (int line = 0; line < 3; line++) begin
      for (int x = 0; x < 800; x++) begin
        de = (x < 640);
        step();
        if (x < 640) begin
          checks++; if (mem_addr !== 19'(exp_a)) begin
            errors++; $display("FAIL frame_addr line=%0d x=%0d got=%0d exp=%0d", line, x, mem_addr, exp_a); end
          exp_a = (exp_a == TB_FB - 1) ? 0 : exp_a + 1;
          reads++;
        end
      end
    end
    checks++; if (reads != 1920 || exp_a != 640) begin
      errors++; $display("FAIL frame_reads got=%0d/%0d exp=1920/640", reads, exp_a); end
    vsync = 1'b0;
    step(); step();
    vsync = 1'b1; de = 1'b1;
    step();
    checks++; if (mem_addr !== 19'd0) begin errors++; $display("FAIL frame_vsync_clear got=%0d exp=0", mem_addr); end
    de = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset_mid_drain();
    int bad = 0;
    de = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_addr = 19'h200 + 19'(i); wr_data = 8'hA0 + 8'(i);
      step();
    end
    wr_valid = 1'b0; de = 1'b0;
    step();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 19'h200 || fifo_cnt !== 5'd5) begin
      errors++; $display("FAIL rst_pre we=%b addr=%h cnt=%0d exp=1/200/5", mem_we, mem_addr, fifo_cnt); end
    rst_n = 1'b0;
    step();
    checks++; if (mem_we !== 1'b0 || fifo_cnt !== 5'd0 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid we=%b cnt=%0d ready=%b exp=0/0/0", mem_we, fifo_cnt, wr_ready); end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (mem_we !== 1'b0) bad++;
    end
    checks++; if (bad != 0 || fifo_cnt !== 5'd0) begin
      errors++; $display("FAIL rst_after we_cycles=%0d cnt=%0d exp=0/0", bad, fifo_cnt); end
    for (int i = 1; i < 6; i++) begin
      checks++; if (rd(19'h200 + 19'(i)) !== f(19'h200 + 19'(i))) begin
        errors++; $display("FAIL rst_ram i=%0d got=%h exp=%h", i, rd(19'h200 + 19'(i)), f(19'h200 + 19'(i))); end
    end
    de = 1'b1;
    step();
    checks++; if (mem_addr !== 19'd0) begin errors++; $display("FAIL rst_scan_restart got=%0d exp=0", mem_addr); end
    de = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; de = 1'b0; vsync = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    test_reset();
    test_scan_line();
    test_drain_in_blanking();
    test_fifo_full();
    test_frame_wrap();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
